// File: rtl/hilbert_transform_fir.sv
`default_nettype none
// ============================================================================
// hilbert_transform_fir : serial-MAC Hilbert FIR fed by setup_HT_coeff
// Option macro HT_SKIP_ODD_TAPS_EN : MAC visits even taps only   | Rev 1.0
// ============================================================================
module hilbert_transform_fir #(
  parameter int LENGTH     = 27,
  parameter int DATA_WIDTH = 18,
  parameter int COEFF_FRAC = 12
) (
  input  logic                         clock,
  input  logic                         resetN,
  input  logic                         enable,
  input  logic                         coeffValid,
  input  logic signed [DATA_WIDTH-1:0] coeffIn,
  output logic                         coeffLoaded,
  input  logic                         dataInValid,
  input  logic signed [DATA_WIDTH-1:0] dataIn,
  output logic                         dataInReady,
  output logic                         dataOutValid,
  output logic signed [DATA_WIDTH-1:0] dataOut,
  output logic signed [DATA_WIDTH-1:0] dataDelayedOut
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(LENGTH);
  localparam int TAP_W  = $clog2(LENGTH + 2);
  localparam int CNT_W  = $clog2(LENGTH);
  localparam int MID    = (LENGTH - 1) / 2;
`ifdef HT_SKIP_ODD_TAPS_EN
  localparam int TAP_STEP = 2;
`else
  localparam int TAP_STEP = 1;
`endif
  localparam logic [TAP_W-1:0] TAP_LAST   = TAP_W'(LENGTH - 1);
  localparam logic [TAP_W-1:0] TAP_INC    = TAP_W'(TAP_STEP);
  localparam logic [CNT_W-1:0] COEFF_LAST = CNT_W'(LENGTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX_D = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN_D = ~SAT_MAX_D;
  localparam logic signed [ACC_W-1:0]      SAT_MAX_W = {{(ACC_W-DATA_WIDTH){1'b0}}, SAT_MAX_D};
  localparam logic signed [ACC_W-1:0]      SAT_MIN_W = ~SAT_MAX_W;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_IDLE = 2'd1,
    S_MAC  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] bank [LENGTH];
  logic signed [DATA_WIDTH-1:0] hist [LENGTH];
  logic        [CNT_W-1:0]      coeff_cnt;
  logic        [TAP_W-1:0]      tap;
  logic signed [ACC_W-1:0]      acc;
  logic                         valid_q;

  logic signed [PROD_W-1:0]     coeff_ext, hist_ext, prod;
  logic signed [ACC_W-1:0]      prod_ext, acc_shift;
  logic signed [DATA_WIDTH-1:0] sat_val;

  assign dataInReady  = enable && (state == S_IDLE);
  // The strobe is held internally across a stall and shown only while enabled.
  assign dataOutValid = valid_q && enable;

  always_comb begin
    coeff_ext = {{DATA_WIDTH{bank[tap][DATA_WIDTH-1]}}, bank[tap]};
    hist_ext  = {{DATA_WIDTH{hist[tap][DATA_WIDTH-1]}}, hist[tap]};
    prod      = coeff_ext * hist_ext;
    prod_ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    acc_shift = acc >>> COEFF_FRAC;
    sat_val   = acc_shift[DATA_WIDTH-1:0];
    if (acc_shift > SAT_MAX_W)      sat_val = SAT_MAX_D;
    else if (acc_shift < SAT_MIN_W) sat_val = SAT_MIN_D;
  end

  always_comb begin
    state_nxt = state;
    if (enable) begin
      case (state)
        S_LOAD: if (coeffValid && coeff_cnt == COEFF_LAST) state_nxt = S_IDLE;
        S_IDLE: if (dataInValid) state_nxt = S_MAC;
        S_MAC:  if (tap == TAP_LAST) state_nxt = S_OUT;
        S_OUT:  state_nxt = S_IDLE;
        default: state_nxt = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= S_LOAD;
    else         state <= state_nxt;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int k = 0; k < LENGTH; k++) begin
        bank[k] <= '0;
        hist[k] <= '0;
      end
      coeff_cnt      <= '0;
      tap            <= '0;
      acc            <= '0;
      valid_q        <= 1'b0;
      coeffLoaded    <= 1'b0;
      dataOut        <= '0;
      dataDelayedOut <= '0;
    end else if (enable) begin
      valid_q <= 1'b0;
      case (state)
        S_LOAD: begin
          // A coincident dataInValid is ignored here: only the coefficient is taken.
          if (coeffValid) begin
            bank[coeff_cnt] <= coeffIn;
            if (coeff_cnt == COEFF_LAST) coeffLoaded <= 1'b1;
            else                         coeff_cnt   <= coeff_cnt + CNT_ONE;
          end
        end
        S_IDLE: begin
          if (dataInValid) begin
            hist[0] <= dataIn;
            for (int k = 1; k < LENGTH; k++) hist[k] <= hist[k-1];
            acc <= '0;
            tap <= '0;
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          tap <= tap + TAP_INC;
        end
        S_OUT: begin
          dataOut        <= sat_val;
          dataDelayedOut <= hist[MID];
          valid_q        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
